// File: rtl/wptr_full_ctrl_if.sv
// Write-side bundle of the async FIFO pointer controller: client request, read-domain Gray pointer in,
// RAM address, Gray pointer out and the full/occupancy/overflow status back to the client.
interface wptr_full_ctrl_if #(
   parameter int DEPTH = 16
) ();
   localparam int AW = $clog2(DEPTH);

   logic          wr_rq;
   logic [AW:0]   rgray_ptr;
   logic          ovf_clr;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr;
   logic          full;
   logic          almost_full;
   logic [AW:0]   wr_count;
   logic          overflow;

   modport master (
      output wr_rq,
      output rgray_ptr,
      output ovf_clr,
      input  waddr,
      input  wptr,
      input  full,
      input  almost_full,
      input  wr_count,
      input  overflow
   );

   modport slave (
      input  wr_rq,
      input  rgray_ptr,
      input  ovf_clr,
      output waddr,
      output wptr,
      output full,
      output almost_full,
      output wr_count,
      output overflow
   );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-domain pointer/flag controller; flags and count register one edge after the write,
// read-pointer effects are seen SYNC_STAGES+1 edges late; writes while full are dropped and flagged.
module wptr_full_ctrl #(
   parameter int DEPTH        = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = DEPTH - 2
) (
   input  logic            w_clk,
   input  logic            rst_n,
   wptr_full_ctrl_if.slave bus
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] AFULL_TH = (AW+1)'(AFULL_THRESH);

   logic [AW:0]                  wbin_q, wbin_d;
   logic [AW:0]                  wptr_q, wptr_d;
   logic                         full_q, full_d;
   logic                         almost_full_q, almost_full_d;
   logic [AW:0]                  wr_count_q, wr_count_d;
   logic                         overflow_q, overflow_d;
   logic [SYNC_STAGES-1:0][AW:0] sync_q, sync_d;

   logic                         wr_en;
   logic [AW:0]                  rgray_s;
   logic [AW:0]                  rbin_s;
   logic [AW:0]                  wgray_next;
   logic [AW:0]                  occ_next;

   always_comb begin : sync_shift
      sync_d    = sync_q;
      sync_d[0] = bus.rgray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign rgray_s = sync_q[SYNC_STAGES-1];

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin : gray_to_bin
      rbin_s = '0;
      for (int i = 0; i <= AW; i++) begin
         rbin_s[i] = ^(rgray_s >> i);
      end
   end

   always_comb begin : next_state
      wr_en      = bus.wr_rq & ~full_q;
      wbin_d     = wbin_q + {{AW{1'b0}}, wr_en};
      wgray_next = (wbin_d >> 1) ^ wbin_d;
      wptr_d     = wgray_next;
      occ_next   = wbin_d - rbin_s;

      // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
      full_d        = (wgray_next == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
      almost_full_d = (occ_next >= AFULL_TH);
      wr_count_d    = occ_next;

      overflow_d = overflow_q;
      if (bus.wr_rq && full_q) begin
         overflow_d = 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q        <= '0;
         wptr_q        <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         wr_count_q    <= '0;
         overflow_q    <= 1'b0;
         sync_q        <= '0;
      end else begin
         wbin_q        <= wbin_d;
         wptr_q        <= wptr_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         wr_count_q    <= wr_count_d;
         overflow_q    <= overflow_d;
         sync_q        <= sync_d;
      end
   end

   assign bus.waddr       = wbin_q[AW-1:0];
   assign bus.wptr        = wptr_q;
   assign bus.full        = full_q;
   assign bus.almost_full = almost_full_q;
   assign bus.wr_count    = wr_count_q;
   assign bus.overflow    = overflow_q;

   // The read domain relies on at most one bit of wptr moving per w_clk edge.
   a_wptr_gray_step : assert property (@(posedge w_clk) disable iff (!rst_n)
      $onehot0(wptr_q ^ $past(wptr_q)));

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: table-driven fill/overflow/drain vectors, hand-written corner sequences,
// and randomized traffic against a count-based occupancy model.
module tb_wptr_full_ctrl;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int SYNC  = 2;
   localparam int ATH   = 14;

   logic w_clk = 1'b0;
   logic rst_n;
   always #5 w_clk = ~w_clk;

   wptr_full_ctrl_if #(.DEPTH(DEPTH)) bus ();

   wptr_full_ctrl #(
      .DEPTH        (DEPTH),
      .SYNC_STAGES  (SYNC),
      .AFULL_THRESH (ATH)
   ) dut (
      .w_clk (w_clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int wr;
      int clr;
      int rd;
      int waddr;
      int wptr;
      int full;
      int af;
      int cnt;
      int ovf;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Model: total accepted writes, read totals seen at each past edge, and the flags derived from them.
   int m_wr;
   int rd_pipe[SYNC];
   int m_full, m_af, m_cnt, m_ovf;

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_waddr"},    int'(bus.waddr),       m_wr % DEPTH);
      chk({tag, "_wptr"},     int'(bus.wptr),        gray(m_wr % (2*DEPTH)));
      chk({tag, "_full"},     int'(bus.full),        m_full);
      chk({tag, "_afull"},    int'(bus.almost_full), m_af);
      chk({tag, "_wr_count"}, int'(bus.wr_count),    m_cnt);
      chk({tag, "_overflow"}, int'(bus.overflow),    m_ovf);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_waddr"},    int'(bus.waddr),       0);
      chk({tag, "_wptr"},     int'(bus.wptr),        0);
      chk({tag, "_full"},     int'(bus.full),        0);
      chk({tag, "_afull"},    int'(bus.almost_full), 0);
      chk({tag, "_wr_count"}, int'(bus.wr_count),    0);
      chk({tag, "_overflow"}, int'(bus.overflow),    0);
   endtask

   task automatic model_clear();
      m_wr = 0;
      for (int i = 0; i < SYNC; i++) rd_pipe[i] = 0;
      m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0;
   endtask

   // One w_clk edge: drive inputs, advance the model, then sample 1ns after the edge.
   task automatic cycle(input int wr, input int clr, input int rd_total, input string tag);
      int used;
      int occ;
      bus.wr_rq     = (wr != 0);
      bus.ovf_clr   = (clr != 0);
      bus.rgray_ptr = 5'(gray(rd_total % (2*DEPTH)));
      used = rd_pipe[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = rd_total;
      if (wr != 0 && m_full != 0)  m_ovf = 1;
      else if (clr != 0)           m_ovf = 0;
      if (wr != 0 && m_full == 0)  m_wr++;
      occ    = m_wr - used;
      m_cnt  = occ;
      m_full = (occ == DEPTH) ? 1 : 0;
      m_af   = (occ >= ATH) ? 1 : 0;
      @(posedge w_clk);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.wr_rq     = 1'b0;
      bus.ovf_clr   = 1'b0;
      bus.rgray_ptr = '0;
      model_clear();
      repeat (2) @(posedge w_clk);
      #1;
      check_zero("rst_hold");
      rst_n = 1'b1;
   endtask

   function automatic void add(input int wr, input int clr, input int rd, input int waddr,
                               input int wptr, input int full, input int af, input int cnt,
                               input int ovf);
      vec_t v;
      v.wr = wr; v.clr = clr; v.rd = rd; v.waddr = waddr; v.wptr = wptr;
      v.full = full; v.af = af; v.cnt = cnt; v.ovf = ovf;
      tbl.push_back(v);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gseq[16];
      int rd;
      int wr;
      int clr;

      gseq = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};
      for (int k = 1; k <= 16; k++)
         add(1, 0, 0, k % 16, gseq[k-1], (k == 16) ? 1 : 0, (k >= 14) ? 1 : 0, k, 0);
      for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 24, 1, 1, 16, 1);
      add(0, 1, 0, 0, 24, 1, 1, 16, 0);
      add(1, 1, 0, 0, 24, 1, 1, 16, 1);
      add(0, 0, 4, 0, 24, 1, 1, 16, 1);
      add(0, 0, 4, 0, 24, 1, 1, 16, 1);
      add(0, 0, 4, 0, 24, 0, 0, 12, 1);
      add(0, 0, 4, 0, 24, 0, 0, 12, 1);

      // Reset values, then an asynchronous reset in the middle of a write burst.
      rst_n = 1'b0;
      bus.wr_rq = 1'b0; bus.ovf_clr = 1'b0; bus.rgray_ptr = '0;
      #1;
      check_zero("rst_init");
      do_reset();
      for (int k = 0; k < 5; k++) cycle(1, 0, 0, "burst");
      bus.wr_rq = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("rst_mid");
      do_reset();

      // Fill, overflow and drain-visibility vectors.
      foreach (tbl[i]) begin
         cycle(tbl[i].wr, tbl[i].clr, tbl[i].rd, "tbl_model");
         chk("tbl_waddr",    int'(bus.waddr),       tbl[i].waddr);
         chk("tbl_wptr",     int'(bus.wptr),        tbl[i].wptr);
         chk("tbl_full",     int'(bus.full),        tbl[i].full);
         chk("tbl_afull",    int'(bus.almost_full), tbl[i].af);
         chk("tbl_wr_count", int'(bus.wr_count),    tbl[i].cnt);
         chk("tbl_overflow", int'(bus.overflow),    tbl[i].ovf);
      end

      // Wrap: 40 writes with the read side trailing by 4 writes.
      do_reset();
      rd = 0;
      for (int k = 0; k < 4; k++) cycle(1, 0, rd, "wrap_pre");
      for (int k = 0; k < 36; k++) begin
         rd++;
         cycle(1, 0, rd, "wrap_wr");
         if (m_wr == 15) chk("wrap_msb_15", int'(bus.wptr[AW]), 0);
         if (m_wr == 16) chk("wrap_msb_16", int'(bus.wptr[AW]), 1);
         if (m_wr == 31) chk("wrap_msb_31", int'(bus.wptr[AW]), 1);
         if (m_wr == 32) chk("wrap_msb_32", int'(bus.wptr[AW]), 0);
         for (int j = 0; j < 3; j++) cycle(0, 0, rd, "wrap_idle");
         chk("wrap_cnt",  int'(bus.wr_count), 4);
         chk("wrap_full", int'(bus.full),     0);
      end

      // Write in the same cycle the synchronised read pointer advances by one.
      do_reset();
      for (int k = 0; k < 15; k++) cycle(1, 0, 0, "sim_fill");
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, "sim_settle");
      chk("sim_pre_cnt", int'(bus.wr_count), 15);
      cycle(0, 0, 1, "sim_rd0");
      cycle(0, 0, 1, "sim_rd1");
      chk("sim_hold_cnt", int'(bus.wr_count), 15);
      cycle(1, 0, 1, "sim_both");
      chk("sim_cnt",   int'(bus.wr_count),    15);
      chk("sim_full",  int'(bus.full),        0);
      chk("sim_afull", int'(bus.almost_full), 1);

      // Randomized traffic with alternating fill-heavy and drain-heavy phases.
      do_reset();
      rd = 0;
      for (int p = 0; p < 8; p++) begin
         for (int k = 0; k < 400; k++) begin
            wr  = ($urandom_range(0, 99) < ((p % 2 == 0) ? 85 : 30)) ? 1 : 0;
            clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
            if (rd < m_wr && $urandom_range(0, 99) < ((p % 2 == 0) ? 25 : 70)) begin
               rd += $urandom_range(1, 3);
               if (rd > m_wr) rd = m_wr;
            end
            cycle(wr, clr, rd, "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
